map_rom_arbiter: RTL and testbench

Shares the single-port map ROM between the VGA renderer and the game-logic collision probes (Fireboy, Watergirl). During active video the renderer always owns the ROM address; during blanking the arbiter grants one probe at a time in round-robin order. Each probe converts a map pixel coordinate to a ROM address, reads the 4-bit palette index and returns it with a one-cycle ack. Sits between the VGA controller, the player/collision logic and the map ROM/palette pair.

---
 rtl/map_pkg.sv | 22 ++
 rtl/map_rom_arbiter_if.sv | 22 ++
 rtl/rr_picker.sv | 31 +++
 rtl/map_rom_arbiter.sv | 130 +++++++++++++
 tb/tb_map_rom_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// map_pkg: constants and types shared by the map ROM arbiter.
//   MAP_W/MAP_H  : map size in pixels (MAP_W is also the ROM row pitch)
//   ADDR_W/DATA_W: map ROM address / data (palette index) widths
//   SCR_W/SCR_H  : visible screen size used to scale DrawX/DrawY onto the map
//   OOB_VAL      : palette index returned for out-of-map probes
//   arb_state_t  : arbiter FSM states
package map_pkg;
    localparam int MAP_W  = 400;
    localparam int MAP_H  = 300;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 4;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam logic [3:0] OOB_VAL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;
endpackage

// File: rtl/map_rom_arbiter_if.sv
// map_rom_arbiter_if: probe request/response bus between the collision
// probes and the map ROM arbiter.
//   req      : per-probe request, held until its ack
//   req_x/y  : per-probe map coordinate, stable while req is high
//   ack      : one-cycle response strobe (one-hot or zero)
//   rsp_data : palette index, valid in the ack cycle only
// Modports: master = probe side, slave = arbiter side.
interface map_rom_arbiter_if
    import map_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = map_pkg::DATA_W
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][9:0]  req_x;
    logic [NREQ-1:0][9:0]  req_y;
    logic [NREQ-1:0]       ack;
    logic [DW-1:0]         rsp_data;

    modport master (output req, req_x, req_y, input ack, rsp_data);
    modport slave  (input req, req_x, req_y, output ack, rsp_data);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req : request vector
//   ptr : index of the last requester served
//   idx : first requester after ptr (cyclically) that is requesting
//   vld : any request present
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            vld
);
    logic [IW-1:0] j;

    // Scan from the farthest candidate to the nearest so the nearest
    // requester after ptr is the last (winning) assignment.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        j   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            j = IW'((int'(ptr) + i) % NREQ);
            if (req[j]) begin
                idx = j;
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares the single-port map ROM between the VGA renderer
// and the collision probes. The renderer owns the ROM address except for the
// single ISSUE cycle of a probe, which is only granted during blanking.
// Ports:
//   vga_clk, reset_n : clock, synchronous active-low reset
//   blank            : 1 = active video, 0 = blanking
//   DrawX, DrawY     : current VGA pixel
//   prb              : probe request/response bus (slave modport)
//   rom_addr, rom_q  : map ROM address (combinational mux) and read data
//   busy             : high while a probe transaction is in flight
// Optional feature: define MAP_ARB_OOB_CHECK_EN to answer out-of-map probes
// with OOB_VAL straight away, without touching the ROM.
module map_rom_arbiter
    import map_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MAP_W   = map_pkg::MAP_W,
    parameter int MAP_H   = map_pkg::MAP_H,
    parameter int ADDR_W  = map_pkg::ADDR_W,
    parameter int DATA_W  = map_pkg::DATA_W,
    parameter int ROM_LAT = 1,
    parameter int H_LAST  = 799,
    parameter logic [DATA_W-1:0] OOB_VAL = DATA_W'(map_pkg::OOB_VAL)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              blank,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    map_rom_arbiter_if.slave  prb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    arb_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     win_q;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;
    logic              win_oob;
    logic              gate_ok;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] probe_addr;
    logic [ADDR_W-1:0] vga_addr;
    logic [18:0]       vx_prod;
    logic [18:0]       vy_prod;
    logic [18:0]       vga_sum;

    // Screen pixel -> map pixel -> ROM address, 19-bit intermediates.
    assign vx_prod  = 19'(DrawX) * 19'(MAP_W);
    assign vy_prod  = 19'(DrawY) * 19'(MAP_H);
    assign vga_sum  = vx_prod / 19'(SCR_W) + (vy_prod / 19'(SCR_H)) * 19'(MAP_W);
    assign vga_addr = ADDR_W'(vga_sum);

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (prb.req),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    assign probe_addr = ADDR_W'(prb.req_y[pick_idx]) * ADDR_W'(MAP_W)
                      + ADDR_W'(prb.req_x[pick_idx]);

`ifdef MAP_ARB_OOB_CHECK_EN
    assign win_oob = (32'(prb.req_x[pick_idx]) >= 32'(MAP_W)) ||
                     (32'(prb.req_y[pick_idx]) >= 32'(MAP_H));
`else
    assign win_oob = 1'b0;
`endif

    // Excluding the last pixel of the line keeps ISSUE (next cycle) out of
    // active video: blanking at H_LAST may be followed by visible pixel 0.
    assign gate_ok = !blank && (DrawX != 10'(H_LAST));

    assign rom_addr = (state == ISSUE) ? addr_q : vga_addr;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= IW'(NREQ - 1);
            win_q        <= '0;
            addr_q       <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            prb.ack      <= '0;
            prb.rsp_data <= '0;
        end else begin
            prb.ack <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_vld && (gate_ok || win_oob)) begin
                        win_q  <= pick_idx;
                        addr_q <= probe_addr;
                        busy   <= 1'b1;
                        if (win_oob) begin
                            prb.rsp_data <= OOB_VAL;
                            prb.ack      <= NREQ'(1) << pick_idx;
                            state        <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(ROM_LAT - 1)) begin
                        prb.rsp_data <= rom_q;
                        prb.ack      <= NREQ'(1) << win_q;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    rr_ptr <= win_q;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_map_rom_arbiter.sv
module tb_map_rom_arbiter;
    import map_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 17;
    localparam int DW   = 4;
    localparam int MW   = 400;
    localparam int MH   = 300;
    localparam int LAT  = 1;

    logic          vga_clk;
    logic          reset_n;
    logic          blank;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          busy;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    map_rom_arbiter_if #(.NREQ(NREQ), .DW(DW)) prb ();

    map_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(LAT)) dut (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .blank    (blank),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .prb      (prb),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .busy     (busy)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM, one cycle of latency.
    always @(posedge vga_clk) rom_q <= mem[rom_addr];

    int err  = 0;
    int nchk = 0;

    // Reference model: a transaction is (grant edge, winner, address, length).
    int  cyc = 0;
    bit  m_act = 0;
    int  m_g, m_L, m_win, m_paddr;
    bit  m_oob;
    int  m_rr = NREQ - 1;
    int  e_busy, e_ack, e_rsp;
    bit  e_issue, rsp_chk;

    function automatic int vga_ref(input int x, input int y);
        return ((x * MW) / 640 + ((y * MH) / 480) * MW) % (1 << AW);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Called at each rising edge: decides what the following cycle must show.
    task automatic model_edge();
        int cand;
        bit oob;
        int k;
        if (!reset_n) begin
            m_act = 0; m_rr = NREQ - 1;
            e_busy = 0; e_ack = 0; e_issue = 0; e_rsp = 0; rsp_chk = 1;
            cyc++;
            return;
        end
        if (m_act && cyc == m_g + m_L) begin
            m_act = 0;
            m_rr  = m_win;
        end else if (!m_act) begin
            cand = -1;
            for (int i = NREQ; i >= 1; i--)
                if (prb.req[(m_rr + i) % NREQ]) cand = (m_rr + i) % NREQ;
            if (cand >= 0) begin
                oob = 0;
`ifdef MAP_ARB_OOB_CHECK_EN
                oob = (prb.req_x[cand] >= MW) || (prb.req_y[cand] >= MH);
`endif
                if (oob || (blank == 1'b0 && DrawX != 10'd799)) begin
                    m_act = 1; m_g = cyc; m_win = cand; m_oob = oob;
                    m_L = oob ? 1 : LAT + 2;
                    m_paddr = (int'(prb.req_y[cand]) * MW + int'(prb.req_x[cand])) % (1 << AW);
                end
            end
        end
        k       = cyc + 1 - m_g;
        e_busy  = m_act ? 1 : 0;
        e_issue = m_act && k == 1 && !m_oob;
        rsp_chk = m_act && k == m_L;
        e_ack   = rsp_chk ? (1 << m_win) : 0;
        e_rsp   = m_oob ? 15 : int'(mem[m_paddr]);
        cyc++;
    endtask

    task automatic compare();
        check("busy", busy, e_busy);
        check("ack", prb.ack, e_ack);
        check("rom_addr", rom_addr, e_issue ? m_paddr : vga_ref(DrawX, DrawY));
        if (rsp_chk) check("rsp_data", prb.rsp_data, e_rsp);
    endtask

    task automatic tick();
        @(posedge vga_clk);
        model_edge();
        @(negedge vga_clk);
        compare();
    endtask

    task automatic set_pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = (x < 640 && y < 480);
    endtask

    task automatic set_req(input int i, input bit v, input int x, input int y);
        prb.req[i]   = v;
        prb.req_x[i] = 10'(x);
        prb.req_y[i] = 10'(y);
    endtask

    // Ticks until ack[who]; t = cycles waited, an expired bound is a failure.
    task automatic wait_ack(input string name, input int who, input int max, output int t);
        bit found = 0;
        t = 0;
        for (int i = 1; i <= max && !found; i++) begin
            tick();
            if (prb.ack[who]) begin found = 1; t = i; end
        end
        check(name, found, 1);
    endtask

    int t;
    int who [3];
    int when [3];
    int n;
    int x, y;

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
        mem[810] = 4'h7;
        reset_n = 0;
        prb.req = '0; prb.req_x = '0; prb.req_y = '0;
        set_pix(700, 100);
        repeat (3) tick();
        check("reset_ack", prb.ack, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp", prb.rsp_data, 0);
        reset_n = 1;
        tick();

        // Both probes held: round-robin 0,1,0 at 4-cycle spacing.
        set_req(0, 1, 1, 1);
        set_req(1, 1, 2, 2);
        n = 0;
        for (int i = 1; i <= 40 && n < 3; i++) begin
            tick();
            if (prb.ack != 0) begin
                who[n]  = prb.ack[1] ? 1 : 0;
                when[n] = i;
                n++;
            end
        end
        prb.req = '0;
        check("rr_count", n, 3);
        if (n == 3) begin
            check("rr_order0", who[0], 0);
            check("rr_order1", who[1], 1);
            check("rr_order2", who[2], 0);
            check("rr_space1", when[1] - when[0], 4);
            check("rr_space2", when[2] - when[1], 4);
        end
        tick();

        // Single probe at (10,2) -> address 810, ack in cycle 3 with 4'h7.
        set_req(0, 1, 10, 2);
        tick();
        check("single_addr", rom_addr, 810);
        tick();
        check("single_ack_c2", prb.ack, 0);
        tick();
        check("single_ack_c3", prb.ack, 2'b01);
        check("single_rsp", prb.rsp_data, 7);
        prb.req = '0;
        tick();

        // Reset during WAIT drops the transaction; held req is served again.
        set_req(0, 1, 20, 5);
        tick();
        tick();
        reset_n = 0;
        tick();
        check("rst_wait_ack", prb.ack, 0);
        check("rst_wait_busy", busy, 0);
        reset_n = 1;
        wait_ack("rst_ack_seen", 0, 10, t);
        check("rst_ack_lat", t, 3);
        prb.req = '0;
        tick();

        // No grant during active video; grant right after blank falls.
        set_req(1, 1, 5, 5);
        for (int i = 0; i < 20; i++) begin
            set_pix(620 + i, 10);
            tick();
            check("blank_nogrant", busy, 0);
        end
        set_pix(640, 10);
        tick();
        check("blank_fall_grant", busy, 1);
        wait_ack("blank_ack_seen", 1, 10, t);
        prb.req = '0;
        tick();

        // Request at H_LAST is not granted; next blanking takes it.
        set_req(0, 1, 3, 3);
        set_pix(799, 10);
        tick();
        check("hlast_nogrant", busy, 0);
        for (int i = 0; i < 3; i++) begin
            set_pix(i, 11);
            tick();
            check("hlast_active", busy, 0);
        end
        set_pix(640, 11);
        tick();
        check("hlast_next_grant", busy, 1);
        wait_ack("hlast_ack_seen", 0, 10, t);
        prb.req = '0;
        tick();

        // Probe at (400,0).
        set_pix(700, 20);
        set_req(0, 1, 400, 0);
        tick();
`ifdef MAP_ARB_OOB_CHECK_EN
        check("oob_ack", prb.ack, 2'b01);
        check("oob_rsp", prb.rsp_data, 15);
        check("oob_addr", rom_addr, 5237);
`else
        check("edge_addr", rom_addr, 400);
        tick();
        tick();
        check("edge_ack", prb.ack, 2'b01);
        check("edge_rsp", prb.rsp_data, mem[400]);
`endif
        prb.req = '0;
        tick();
        tick();

        // Randomized traffic over a running raster.
        x = 0;
        y = $urandom_range(0, 524);
        for (int c = 0; c < 6000; c++) begin
            set_pix(x, y);
            reset_n = ($urandom_range(0, 599) != 0);
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (prb.ack[i]) prb.req[i] = 1'b0;
                else if (!prb.req[i] && $urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 1, $urandom_range(0, 1023), $urandom_range(0, 1023));
                    else
                        set_req(i, 1, $urandom_range(0, MW - 1), $urandom_range(0, MH - 1));
                end
            end
            x = x + 1;
            if (x == 800) begin x = 0; y = (y + 1) % 525; end
        end

        $display("Result: errors=%0d of %0d checks", err, nchk);
        $finish;
    end
endmodule
